mandelbrot_fpga: RTL and testbench



---
 rtl/mandelbrot_fpga_if.sv | 14 +
 rtl/mandelbrot_fpga.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mandelbrot_fpga.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_fpga_if.sv
// VGA output bundle of the Mandelbrot renderer: syncs, active-area flag and colour.
interface mandelbrot_fpga_if #(
    parameter int VW = 8
);
    logic          vga_hsync;
    logic          vga_vsync;
    logic          vga_vld;
    logic [VW-1:0] vga_r;
    logic [VW-1:0] vga_g;
    logic [VW-1:0] vga_b;

    modport master (output vga_hsync, vga_vsync, vga_vld, vga_r, vga_g, vga_b);
    modport slave  (input  vga_hsync, vga_vsync, vga_vld, vga_r, vga_g, vga_b);
endinterface

// File: rtl/mandelbrot_fpga.sv
// Mandelbrot renderer: escape-time engine fills an index RAM once after reset,
// while a VGA scan-out continuously reads it through a palette.
module mandelbrot_coord_gen #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int FPW     = 16,
    parameter int AW      = 19,
    parameter int CR0     = -8192,
    parameter int CI0     = -4800,
    parameter int CR_STEP = 20,
    parameter int CI_STEP = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  pix_done,
    output logic signed [FPW-1:0] cr,
    output logic signed [FPW-1:0] ci,
    output logic [AW-1:0]         addr,
    output logic                  cnt_en
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic          last_x;
    logic          last_y;

    assign last_x = (x_reg == XW'(WIDTH - 1));
    assign last_y = (y_reg == YW'(HEIGHT - 1));

    // c and the RAM address advance incrementally alongside x/y
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg  <= '0;
            y_reg  <= '0;
            cr     <= FPW'(CR0);
            ci     <= FPW'(CI0);
            addr   <= '0;
            cnt_en <= 1'b1;
        end else if (clk_en && cnt_en && pix_done) begin
            addr <= addr + 1'b1;
            if (last_x) begin
                x_reg <= '0;
                cr    <= FPW'(CR0);
                if (last_y) begin
                    y_reg  <= '0;
                    ci     <= FPW'(CI0);
                    addr   <= '0;
                    cnt_en <= 1'b0;
                end else begin
                    y_reg <= y_reg + 1'b1;
                    ci    <= ci + FPW'(CI_STEP);
                end
            end else begin
                x_reg <= x_reg + 1'b1;
                cr    <= cr + FPW'(CR_STEP);
            end
        end
    end
endmodule

module mandelbrot_index_ram #(
    parameter int DEPTH = 307200,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          clk_en,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (we)
                mem[waddr] <= wdata;
            rdata <= mem[raddr];
        end
    end
endmodule

module mandelbrot_video #(
    parameter int VW     = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int HFP    = 16,
    parameter int HSW    = 96,
    parameter int HBP    = 48,
    parameter int VFP    = 10,
    parameter int VSW    = 2,
    parameter int VBP    = 33,
    parameter int AW     = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              blank,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [7:0]        wdata,
    mandelbrot_fpga_if.master vga
);
    localparam int HT  = WIDTH + HFP + HSW + HBP;
    localparam int VT  = HEIGHT + VFP + VSW + VBP;
    localparam int HCW = $clog2(HT);
    localparam int VCW = $clog2(VT);
    localparam logic [HCW-1:0] H_LAST = HCW'(HT - 1);
    localparam logic [HCW-1:0] H_ACT  = HCW'(WIDTH);
    localparam logic [HCW-1:0] HS_ON  = HCW'(WIDTH + HFP);
    localparam logic [HCW-1:0] HS_OFF = HCW'(WIDTH + HFP + HSW);
    localparam logic [VCW-1:0] V_LAST = VCW'(VT - 1);
    localparam logic [VCW-1:0] V_ACT  = VCW'(HEIGHT);
    localparam logic [VCW-1:0] VS_ON  = VCW'(HEIGHT + VFP);
    localparam logic [VCW-1:0] VS_OFF = VCW'(HEIGHT + VFP + VSW);

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           active, hs_now, vs_now;
    logic [AW-1:0]  raddr;
    logic [7:0]     idx;
    logic           vld_d1, hs_d1, vs_d1;
    logic [7:0]     r8, g8, b8;
    logic [VW-1:0]  r_w, g_w, b_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clk_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_now = !((h_cnt >= HS_ON) && (h_cnt < HS_OFF));
        vs_now = !((v_cnt >= VS_ON) && (v_cnt < VS_OFF));
        raddr  = active ? AW'(32'(v_cnt) * WIDTH + 32'(h_cnt)) : '0;
    end

    mandelbrot_index_ram #(.DEPTH(WIDTH * HEIGHT), .AW(AW)) video_index_ram (
        .clk   (clk),
        .clk_en(clk_en),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (idx)
    );

    // Stage 1 runs beside the RAM read so syncs line up with the palette stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_d1 <= 1'b0;
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
        end else if (clk_en) begin
            vld_d1 <= active;
            hs_d1  <= hs_now;
            vs_d1  <= vs_now;
        end
    end

    always_comb begin
        r8 = '0;
        g8 = '0;
        b8 = '0;
        if (vld_d1 && !blank && idx != 8'd0) begin
            r8 = idx;
            g8 = {idx[3:0], idx[7:4]};
            b8 = ~idx;
        end
    end

    // Repeat each 8-bit component MSB-first across the output width
    genvar gi;
    for (gi = 0; gi < VW; gi++) begin : g_rep
        assign r_w[gi] = r8[7 - ((VW - 1 - gi) % 8)];
        assign g_w[gi] = g8[7 - ((VW - 1 - gi) % 8)];
        assign b_w[gi] = b8[7 - ((VW - 1 - gi) % 8)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga.vga_hsync <= 1'b1;
            vga.vga_vsync <= 1'b1;
            vga.vga_vld   <= 1'b0;
            vga.vga_r     <= '0;
            vga.vga_g     <= '0;
            vga.vga_b     <= '0;
        end else if (clk_en) begin
            vga.vga_hsync <= hs_d1;
            vga.vga_vsync <= vs_d1;
            vga.vga_vld   <= vld_d1;
            vga.vga_r     <= r_w;
            vga.vga_g     <= g_w;
            vga.vga_b     <= b_w;
        end
    end
endmodule

module mandelbrot_fpga #(
    parameter int VW      = 8,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int MAXIT   = 255,
    parameter int FPW     = 16,
    parameter int CR0     = -8192,
    parameter int CI0     = -4800,
    parameter int CR_STEP = 20,
    parameter int CI_STEP = 20,
    parameter int HFP     = 16,
    parameter int HSW     = 96,
    parameter int HBP     = 48,
    parameter int VFP     = 10,
    parameter int VSW     = 2,
    parameter int VBP     = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    mandelbrot_fpga_if.master vga
);
    localparam int AW   = $clog2(WIDTH * HEIGHT);
    localparam int FRAC = FPW - 4;
    localparam logic [2*FPW:0] ESC = (2*FPW+1)'(1) << (2*FRAC + 2);

    logic signed [FPW-1:0]   cr, ci, zr_reg, zi_reg, zr_next, zi_next;
    logic signed [2*FPW-1:0] zr2, zi2, zrzi;
    logic [2*FPW:0]          mag;
    logic [7:0]              n_reg, idx;
    logic                    escape, pix_done, we, cnt_en;
    logic [AW-1:0]           addr;

    mandelbrot_coord_gen #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FPW(FPW), .AW(AW),
        .CR0(CR0), .CI0(CI0), .CR_STEP(CR_STEP), .CI_STEP(CI_STEP)
    ) mandelbrot_coords (
        .clk(clk), .rst(rst), .clk_en(clk_en), .pix_done(pix_done),
        .cr(cr), .ci(ci), .addr(addr), .cnt_en(cnt_en)
    );

    always_comb begin
        zr2      = (2*FPW)'(zr_reg) * (2*FPW)'(zr_reg);
        zi2      = (2*FPW)'(zi_reg) * (2*FPW)'(zi_reg);
        zrzi     = (2*FPW)'(zr_reg) * (2*FPW)'(zi_reg);
        mag      = {zr2[2*FPW-1], zr2} + {zi2[2*FPW-1], zi2};
        escape   = (mag >= ESC);
        pix_done = escape || (n_reg == 8'(MAXIT));
        idx      = escape ? n_reg : 8'd0;
        zr_next  = cr + FPW'((zr2 - zi2) >>> FRAC);
        // (2*zr*zi)>>>FRAC taken as zr*zi>>>(FRAC-1): same floor, no product overflow
        zi_next  = ci + FPW'(zrzi >>> (FRAC - 1));
    end

    assign we = clk_en && cnt_en && pix_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zr_reg <= '0;
            zi_reg <= '0;
            n_reg  <= '0;
        end else if (clk_en && cnt_en) begin
            if (pix_done) begin
                zr_reg <= '0;
                zi_reg <= '0;
                n_reg  <= '0;
            end else begin
                zr_reg <= zr_next;
                zi_reg <= zi_next;
                n_reg  <= n_reg + 1'b1;
            end
        end
    end

    mandelbrot_video #(
        .VW(VW), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .HFP(HFP), .HSW(HSW), .HBP(HBP), .VFP(VFP), .VSW(VSW), .VBP(VBP), .AW(AW)
    ) video_pipe (
        .clk(clk), .rst(rst), .clk_en(clk_en), .blank(cnt_en),
        .we(we), .waddr(addr), .wdata(idx), .vga(vga)
    );
endmodule

// File: tb/tb_mandelbrot_fpga.sv
// Bench for mandelbrot_fpga on a reduced 24x12 frame: checks RAM and scanned-out frames
// against an escape-time reference model, plus sync geometry, latency and clock-enable hold.
`timescale 1ns/1ps
module tb_mandelbrot_fpga;
    localparam int VW = 8, W = 24, H = 12, MAXIT = 31;
    localparam int CR0 = -8192, CI0 = -4800, CRS = 512, CIS = 800;
    localparam int HFP = 2, HSW = 4, HBP = 3, VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = W + HFP + HSW + HBP;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    int   en_mode = 0;
    int   tests = 0;
    int   fails = 0;

    mandelbrot_fpga_if #(.VW(VW)) vga_bus ();

    mandelbrot_fpga #(
        .VW(VW), .WIDTH(W), .HEIGHT(H), .MAXIT(MAXIT), .FPW(16),
        .CR0(CR0), .CI0(CI0), .CR_STEP(CRS), .CI_STEP(CIS),
        .HFP(HFP), .HSW(HSW), .HBP(HBP), .VFP(VFP), .VSW(VSW), .VBP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .vga(vga_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        int         idx;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;
    vec_t vecs [5];
    int   exp_idx [NPIX];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Escape-time count straight from the iteration rules, in wide integers
    function automatic int ref_idx(input int x, input int y);
        longint cr, ci, zr, zi, t;
        cr = CR0 + CRS * x;
        ci = CI0 + CIS * y;
        zr = 0;
        zi = 0;
        for (int n = 0; n <= MAXIT; n++) begin
            if (zr * zr + zi * zi >= longint'(67108864)) return n;
            t  = ((zr * zr - zi * zi) >>> 12) + cr;
            zi = ((2 * zr * zi) >>> 12) + ci;
            zr = t;
        end
        return 0;
    endfunction

    function automatic logic [23:0] pal(input int idx);
        logic [7:0] v;
        v = 8'(idx);
        if (v == 8'd0) return 24'h0;
        return {v, v[3:0], v[7:4], ~v};
    endfunction

    // clk_en driver: steady, toggling, or random
    initial forever begin
        @(posedge clk);
        #2;
        case (en_mode)
            0:       clk_en = 1'b1;
            1:       clk_en = ~clk_en;
            default: clk_en = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: only samples following an enabled edge count as new cycles
    logic        en_q = 1'b1;
    logic [23:0] cur_frame [NPIX];
    logic [23:0] last_frame [NPIX];
    logic [23:0] prev_frame [NPIX];
    int pix_p = 0, frames_done = 0, last_vld_cnt = 0;
    int hs_run = 0, hs_width = 0, vs_run = 0, vs_width = 0;
    int ecyc = 0, hs_fall_at = -1, hs_period = 0;
    int hold_viol = 0, off_viol = 0;
    logic        prev_hs = 1'b1, prev_vs = 1'b1, prev_vld = 1'b0, prev_valid = 1'b0;
    logic [23:0] prev_rgb = '0;

    always @(posedge clk) en_q = clk_en;

    always @(negedge clk) begin
        logic [23:0] rgb;
        logic hs, vs, vld;
        rgb = {vga_bus.vga_r, vga_bus.vga_g, vga_bus.vga_b};
        hs  = vga_bus.vga_hsync;
        vs  = vga_bus.vga_vsync;
        vld = vga_bus.vga_vld;
        if (rst) begin
            pix_p = 0; hs_run = 0; vs_run = 0; hs_fall_at = -1; prev_valid = 1'b0;
        end else begin
            if (!en_q) begin
                if (prev_valid && {hs, vs, vld, rgb} !== {prev_hs, prev_vs, prev_vld, prev_rgb})
                    hold_viol++;
            end else begin
                ecyc++;
                if (vld) begin
                    if (pix_p < NPIX) cur_frame[pix_p] = rgb;
                    pix_p++;
                end else if (rgb != 24'h0) begin
                    off_viol++;
                end
                if (!hs) hs_run++;
                else if (!prev_hs) begin hs_width = hs_run; hs_run = 0; end
                if (!hs && prev_hs) begin
                    if (hs_fall_at >= 0) hs_period = ecyc - hs_fall_at;
                    hs_fall_at = ecyc;
                end
                if (!vs) vs_run++;
                else if (!prev_vs) begin vs_width = vs_run; vs_run = 0; end
                if (!vs && prev_vs) begin
                    prev_frame   = last_frame;
                    last_frame   = cur_frame;
                    last_vld_cnt = pix_p;
                    pix_p        = 0;
                    frames_done++;
                end
            end
            prev_hs = hs; prev_vs = vs; prev_vld = vld; prev_rgb = rgb; prev_valid = 1'b1;
        end
    end

    task automatic wait_done(input int budget, input string name);
        int i;
        i = 0;
        while (dut.mandelbrot_coords.cnt_en && i < budget) begin
            @(posedge clk);
            i++;
        end
        @(negedge clk);
        check({name, " cnt_en fall"}, 64'(dut.mandelbrot_coords.cnt_en), 64'(0));
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (frames_done < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        @(negedge clk);
        check({name, " frames"}, 64'(frames_done >= target), 64'(1));
    endtask

    task automatic verify_all(input string name);
        int bad_mem, bad_pix, bad_rep;
        bad_mem = 0; bad_pix = 0; bad_rep = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (dut.video_pipe.video_index_ram.mem[a] !== 8'(exp_idx[a])) bad_mem++;
            if (last_frame[a] !== pal(exp_idx[a])) bad_pix++;
            if (last_frame[a] !== prev_frame[a]) bad_rep++;
        end
        check({name, " mem mismatches"}, 64'(bad_mem), 64'(0));
        check({name, " frame mismatches"}, 64'(bad_pix), 64'(0));
        check({name, " frame repeat diffs"}, 64'(bad_rep), 64'(0));
        check({name, " vld per frame"}, 64'(last_vld_cnt), 64'(NPIX));
        check({name, " hsync width"}, 64'(hs_width), 64'(HSW));
        check({name, " line period"}, 64'(hs_period), 64'(HT));
        check({name, " vsync width"}, 64'(vs_width), 64'(VSW * HT));
        check({name, " hold violations"}, 64'(hold_viol), 64'(0));
        check({name, " rgb outside active"}, 64'(off_viol), 64'(0));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int f0, d;
        for (int a = 0; a < NPIX; a++) exp_idx[a] = ref_idx(a % W, a / W);
        vecs[0] = '{0,  0,  1, 8'h01, 8'h10, 8'hFE};
        vecs[1] = '{0,  11, 1, 8'h01, 8'h10, 8'hFE};
        vecs[2] = '{16, 6,  0, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{8,  6,  0, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{20, 6,  5, 8'h05, 8'h50, 8'hFA};

        // Reset state and video latency
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst hsync", 64'(vga_bus.vga_hsync), 64'(1));
        check("rst vsync", 64'(vga_bus.vga_vsync), 64'(1));
        check("rst vld", 64'(vga_bus.vga_vld), 64'(0));
        check("rst rgb", 64'({vga_bus.vga_r, vga_bus.vga_g, vga_bus.vga_b}), 64'(0));
        check("rst cnt_en", 64'(dut.mandelbrot_coords.cnt_en), 64'(1));
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("vld after 1 edge", 64'(vga_bus.vga_vld), 64'(0));
        @(posedge clk); @(negedge clk);
        check("vld after 2 edges", 64'(vga_bus.vga_vld), 64'(1));
        check("rgb blank while busy", 64'({vga_bus.vga_r, vga_bus.vga_g, vga_bus.vga_b}), 64'(0));
        $display("[TB] phase 1: full-rate render");
        wait_done(20000, "p1");
        f0 = frames_done;
        wait_frames(f0 + 3, 5000, "p1");
        verify_all("p1");
        for (int i = 0; i < 5; i++) begin
            int a;
            a = vecs[i].y * W + vecs[i].x;
            $display("[TB] vector (%0d,%0d) idx=%0d", vecs[i].x, vecs[i].y, vecs[i].idx);
            check($sformatf("vec(%0d,%0d) mem", vecs[i].x, vecs[i].y),
                  64'(dut.video_pipe.video_index_ram.mem[a]), 64'(vecs[i].idx));
            check($sformatf("vec(%0d,%0d) rgb", vecs[i].x, vecs[i].y),
                  64'(last_frame[a]), 64'({vecs[i].r, vecs[i].g, vecs[i].b}));
        end

        // clk_en alternating every cycle
        $display("[TB] phase 2: clk_en toggling");
        en_mode = 1;
        pulse_reset();
        @(negedge clk);
        check("p2 cnt_en after reset", 64'(dut.mandelbrot_coords.cnt_en), 64'(1));
        wait_done(40000, "p2");
        f0 = frames_done;
        wait_frames(f0 + 3, 10000, "p2");
        verify_all("p2");

        // Random clk_en, reset asserted mid-calculation
        en_mode = 2;
        pulse_reset();
        d = $urandom_range(300, 3000);
        $display("[TB] phase 3: random clk_en, mid-run reset after %0d cycles", d);
        repeat (d) @(posedge clk);
        @(negedge clk);
        check("p3 busy before reset", 64'(dut.mandelbrot_coords.cnt_en), 64'(1));
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        check("p3 cnt_en in reset", 64'(dut.mandelbrot_coords.cnt_en), 64'(1));
        check("p3 addr in reset", 64'(dut.mandelbrot_coords.addr), 64'(0));
        @(posedge clk); #2 rst = 1'b0;
        wait_done(40000, "p3");
        f0 = frames_done;
        wait_frames(f0 + 3, 10000, "p3");
        verify_all("p3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
